// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the fifo packet arbiter.
//   arb_state_t : arbiter FSM state (IDLE waits for a request, GRANT streams one packet)
//   idx_width() : width of a requester index for a given requester count
package fifo_arb_pkg;

    typedef enum logic {IDLE, GRANT} arb_state_t;

    // Never returns 0, so a degenerate count still yields a legal vector width.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
// Finds the first set request bit strictly above ptr_i, wrapping modulo N_REQ.
// The bit at ptr_i itself is checked last, so it has the lowest priority.
//   req_i : request vector, one bit per requester
//   ptr_i : index of the most recently granted requester
//   any_o : at least one request bit is set
//   idx_o : index of the selected requester (0 when any_o is low)
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned IDX_W = idx_width(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic             any_o,
    output logic [IDX_W-1:0] idx_o
);

    int unsigned cand;

    always_comb begin
        any_o = 1'b0;
        idx_o = '0;
        cand  = 0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            cand = (32'(ptr_i) + k) % N_REQ;
            if (!any_o && req_i[IDX_W'(cand)]) begin
                any_o = 1'b1;
                idx_o = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/fifo_pkt_arbiter.sv
// Packet-atomic round-robin arbiter sharing one fifo write port among N_REQ
// stream requesters. A grant is held until the granted requester's last beat
// is written; there is always one idle cycle between packets.
//   clk, rst     : clock and asynchronous active-high reset
//   s_valid_i    : per-requester beat valid
//   s_data_i     : requester r payload at [r*T_DATA_WIDTH +: T_DATA_WIDTH]
//   s_last_i     : per-requester end-of-packet flag
//   s_ready_o    : per-requester ready (only the granted bit, only when fifo not full)
//   fifo_push_o  : fifo push strobe
//   fifo_data_o  : {last, data} for the fifo
//   fifo_full_i  : fifo full
//   busy_o       : a packet grant is active
//   grant_o      : current or most recent granted requester
//   pkt_cnt_o    : completed packets since reset, wrapping
module fifo_pkt_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int unsigned T_DATA_WIDTH = 8,
    parameter int unsigned N_REQ        = 4,
    parameter int unsigned CNT_WIDTH    = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [N_REQ-1:0]                s_valid_i,
    input  logic [N_REQ*T_DATA_WIDTH-1:0]   s_data_i,
    input  logic [N_REQ-1:0]                s_last_i,
    output logic [N_REQ-1:0]                s_ready_o,
    output logic                            fifo_push_o,
    output logic [T_DATA_WIDTH:0]           fifo_data_o,
    input  logic                            fifo_full_i,
    output logic                            busy_o,
    output logic [idx_width(N_REQ)-1:0]     grant_o,
    output logic [CNT_WIDTH-1:0]            pkt_cnt_o
);

    localparam int unsigned IDX_W = idx_width(N_REQ);

    arb_state_t              state_q;
    logic [IDX_W-1:0]        grant_q;
    logic [IDX_W-1:0]        rr_q;
    logic [CNT_WIDTH-1:0]    cnt_q;

    logic                    pick_any;
    logic [IDX_W-1:0]        pick_idx;

    logic                    sel_valid;
    logic                    sel_last;
    logic [T_DATA_WIDTH-1:0] sel_data;
    logic                    busy;
    logic                    push;

    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req_i (s_valid_i),
        .ptr_i (rr_q),
        .any_o (pick_any),
        .idx_o (pick_idx)
    );

    // Select the granted requester's beat.
    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = '0;
        for (int unsigned r = 0; r < N_REQ; r++) begin
            if (grant_q == IDX_W'(r)) begin
                sel_valid = s_valid_i[r];
                sel_last  = s_last_i[r];
                sel_data  = s_data_i[r*T_DATA_WIDTH +: T_DATA_WIDTH];
            end
        end
    end

    // Ready does not depend on valid, so a paused requester still sees ready.
    always_comb begin
        busy      = (state_q == GRANT);
        push      = busy && sel_valid && !fifo_full_i;
        s_ready_o = '0;
        if (busy && !fifo_full_i) begin
            s_ready_o[grant_q] = 1'b1;
        end
    end

    assign fifo_push_o = push;
    assign fifo_data_o = {sel_last, sel_data};
    assign busy_o      = busy;
    assign grant_o     = grant_q;
    assign pkt_cnt_o   = cnt_q;

    // rr_q starts at the top index so requester 0 wins the first arbitration.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            rr_q    <= IDX_W'(N_REQ - 1);
            cnt_q   <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (pick_any) begin
                        grant_q <= pick_idx;
                        rr_q    <= pick_idx;
                        state_q <= GRANT;
                    end
                end
                GRANT: begin
                    if (push && sel_last) begin
                        state_q <= IDLE;
                        cnt_q   <= cnt_q + CNT_WIDTH'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_pkt_arbiter.sv
// Directed table-driven bench for fifo_pkt_arbiter (4 requesters, 8-bit data,
// 4-bit packet counter). Each table row is one clock cycle: inputs are driven
// on the falling edge and outputs compared 1 time unit later.
module tb_fifo_pkt_arbiter;

    localparam int unsigned W  = 8;
    localparam int unsigned N  = 4;
    localparam int unsigned CW = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    s_valid = '0;
    logic [N*W-1:0]  s_data  = '0;
    logic [N-1:0]    s_last  = '0;
    logic [N-1:0]    s_ready;
    logic            fifo_push;
    logic [W:0]      fifo_data;
    logic            fifo_full = 1'b0;
    logic            busy;
    logic [1:0]      grant;
    logic [CW-1:0]   pkt_cnt;

    always #5 clk = ~clk;

    fifo_pkt_arbiter #(
        .T_DATA_WIDTH (W),
        .N_REQ        (N),
        .CNT_WIDTH    (CW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .s_valid_i   (s_valid),
        .s_data_i    (s_data),
        .s_last_i    (s_last),
        .s_ready_o   (s_ready),
        .fifo_push_o (fifo_push),
        .fifo_data_o (fifo_data),
        .fifo_full_i (fifo_full),
        .busy_o      (busy),
        .grant_o     (grant),
        .pkt_cnt_o   (pkt_cnt)
    );

    typedef struct {
        int          tid;
        logic        rst;
        logic [3:0]  valid;
        logic [31:0] data;
        logic [3:0]  last;
        logic        full;
        logic [3:0]  e_ready;
        logic        e_push;
        logic [8:0]  e_fdata;
        logic        e_busy;
        logic [1:0]  e_grant;
        logic [3:0]  e_cnt;
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic v(input int tid, input int r, input int valid, input logic [31:0] data,
                     input int last, input int full, input int e_ready, input int e_push,
                     input int e_fdata, input int e_busy, input int e_grant, input int e_cnt);
        vec_t x;
        x.tid     = tid;
        x.rst     = 1'(r);
        x.valid   = 4'(valid);
        x.data    = data;
        x.last    = 4'(last);
        x.full    = 1'(full);
        x.e_ready = 4'(e_ready);
        x.e_push  = 1'(e_push);
        x.e_fdata = 9'(e_fdata);
        x.e_busy  = 1'(e_busy);
        x.e_grant = 2'(e_grant);
        x.e_cnt   = 4'(e_cnt);
        vecs.push_back(x);
    endtask

    task automatic check_val(input string name, input int act, input int req);
        n_vec++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    localparam logic [31:0] D0  = 32'h4433_2211;
    localparam logic [31:0] DA1 = 32'h00A1_5500;
    localparam logic [31:0] DA2 = 32'h00A2_5500;
    localparam logic [31:0] DA3 = 32'h00A3_5500;
    localparam logic [31:0] D3  = 32'h7700_0000;

    initial begin
        int  pushes;
        logic ok;

        // Reset state
        v(0, 1, 'hF, D0, 0, 0,  0, 0, 'h000, 0, 0, 0);
        // Test 1: all requesters valid, 2-beat packets -> grants 0,1,2,3,0
        v(1, 0, 'hF, D0, 0, 0,  0, 0, 'h000, 0, 0, 0);
        v(1, 0, 'hF, D0, 0, 0,  1, 1, 'h011, 1, 0, 0);
        v(1, 0, 'hF, D0, 1, 0,  1, 1, 'h111, 1, 0, 0);
        v(1, 0, 'hF, D0, 0, 0,  0, 0, 'h000, 0, 0, 1);
        v(1, 0, 'hF, D0, 0, 0,  2, 1, 'h022, 1, 1, 1);
        v(1, 0, 'hF, D0, 2, 0,  2, 1, 'h122, 1, 1, 1);
        v(1, 0, 'hF, D0, 0, 0,  0, 0, 'h000, 0, 1, 2);
        v(1, 0, 'hF, D0, 0, 0,  4, 1, 'h033, 1, 2, 2);
        v(1, 0, 'hF, D0, 4, 0,  4, 1, 'h133, 1, 2, 2);
        v(1, 0, 'hF, D0, 0, 0,  0, 0, 'h000, 0, 2, 3);
        v(1, 0, 'hF, D0, 0, 0,  8, 1, 'h044, 1, 3, 3);
        v(1, 0, 'hF, D0, 8, 0,  8, 1, 'h144, 1, 3, 3);
        v(1, 0, 'hF, D0, 0, 0,  0, 0, 'h000, 0, 3, 4);
        v(1, 0, 'hF, D0, 0, 0,  1, 1, 'h011, 1, 0, 4);
        v(1, 0, 'hF, D0, 1, 0,  1, 1, 'h111, 1, 0, 4);
        v(1, 0, 'h0, D0, 0, 0,  0, 0, 'h000, 0, 0, 5);
        // Test 2: requester 2 streams 3 beats while requester 1 waits
        v(2, 0, 'h4, DA1, 0, 0, 0, 0, 'h000, 0, 0, 5);
        v(2, 0, 'h6, DA1, 0, 0, 4, 1, 'h0A1, 1, 2, 5);
        v(2, 0, 'h6, DA2, 0, 0, 4, 1, 'h0A2, 1, 2, 5);
        v(2, 0, 'h6, DA3, 4, 0, 4, 1, 'h1A3, 1, 2, 5);
        v(2, 0, 'h2, DA3, 0, 0, 0, 0, 'h000, 0, 2, 6);
        v(2, 0, 'h2, DA3, 2, 0, 2, 1, 'h155, 1, 1, 6);
        v(2, 0, 'h0, DA3, 0, 0, 0, 0, 'h000, 0, 1, 7);
        // Test 3: fifo full for 4 cycles mid-packet (last offered while full)
        v(3, 0, 'h8, D3, 0, 0,  0, 0, 'h000, 0, 1, 7);
        v(3, 0, 'h8, D3, 0, 0,  8, 1, 'h077, 1, 3, 7);
        for (int i = 0; i < 4; i++) v(3, 0, 'h8, D3, 8, 1, 0, 0, 'h000, 1, 3, 7);
        v(3, 0, 'h8, D3, 8, 0,  8, 1, 'h177, 1, 3, 7);
        v(3, 0, 'h0, D3, 0, 0,  0, 0, 'h000, 0, 3, 8);
        // Test 4: granted requester drops valid 3 cycles, others valid
        v(4, 0, 'h1, D0, 0, 0,  0, 0, 'h000, 0, 3, 8);
        v(4, 0, 'hF, D0, 0, 0,  1, 1, 'h011, 1, 0, 8);
        for (int i = 0; i < 3; i++) v(4, 0, 'hE, D0, 1, 0, 1, 0, 'h000, 1, 0, 8);
        v(4, 0, 'hF, D0, 1, 0,  1, 1, 'h111, 1, 0, 8);
        v(4, 0, 'h0, D0, 0, 0,  0, 0, 'h000, 0, 0, 9);
        // Test 5: reset asserted during beat 2 of a packet
        v(5, 0, 'h2, D0, 0, 0,  0, 0, 'h000, 0, 0, 9);
        v(5, 0, 'h2, D0, 0, 0,  2, 1, 'h022, 1, 1, 9);
        v(5, 1, 'h2, D0, 0, 0,  0, 0, 'h000, 0, 0, 0);
        v(5, 1, 'hF, D0, 0, 0,  0, 0, 'h000, 0, 0, 0);
        v(5, 0, 'hF, D0, 0, 0,  0, 0, 'h000, 0, 0, 0);
        v(5, 0, 'hF, D0, 1, 0,  1, 1, 'h111, 1, 0, 0);
        v(5, 0, 'h0, D0, 0, 0,  0, 0, 'h000, 0, 0, 1);

        repeat (2) @(posedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            rst       = vecs[i].rst;
            s_valid   = vecs[i].valid;
            s_data    = vecs[i].data;
            s_last    = vecs[i].last;
            fifo_full = vecs[i].full;
            #1;
            ok = (s_ready === vecs[i].e_ready) && (fifo_push === vecs[i].e_push) &&
                 (busy === vecs[i].e_busy) && (grant === vecs[i].e_grant) &&
                 (pkt_cnt === vecs[i].e_cnt) &&
                 (!vecs[i].e_push || fifo_data === vecs[i].e_fdata);
            n_vec++;
            if (!ok) begin
                n_bad++;
                $display({"FAIL vec%0d (test %0d): got ready=%h push=%b data=%h busy=%b ",
                          "grant=%0d cnt=%0d, required ready=%h push=%b data=%h busy=%b ",
                          "grant=%0d cnt=%0d"},
                         i, vecs[i].tid, s_ready, fifo_push, fifo_data, busy, grant, pkt_cnt,
                         vecs[i].e_ready, vecs[i].e_push, vecs[i].e_fdata, vecs[i].e_busy,
                         vecs[i].e_grant, vecs[i].e_cnt);
            end
        end

        // Test 6: 16 single-beat packets wrap the 4-bit counter back to 0
        @(negedge clk);
        rst       = 1'b1;
        s_valid   = '0;
        s_last    = '0;
        fifo_full = 1'b0;
        @(negedge clk);
        rst     = 1'b0;
        s_valid = 4'b0100;
        s_last  = 4'b0100;
        s_data  = D0;
        pushes  = 0;
        for (int i = 0; i < 32; i++) begin
            #1;
            if (fifo_push === 1'b1) pushes++;
            if (i == 30) check_val("cnt_before_wrap", int'(pkt_cnt), 15);
            if (i == 31) check_val("wrap_grant", int'(grant), 2);
            @(negedge clk);
        end
        #1;
        check_val("cnt_wrapped", int'(pkt_cnt), 0);
        check_val("wrap_pushes", pushes, 16);
        check_val("wrap_idle_busy", int'(busy), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
